// File: rtl/store_byte_packer.sv
// Store byte packer: turns an M-stage store into a word-aligned,
// lane-replicated memory write, flags misaligned stores (AdES) and
// buffers accepted stores in a small FIFO drained over a req/ack handshake.
module store_byte_packer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_option,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_byteen,
  input  logic          mem_ack,
  output logic          exc_ades,
  output logic [AW-1:0] exc_addr,
  output logic          busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [2:0] OPT_SW = 3'b001;
  localparam logic [2:0] OPT_SH = 3'b010;
  localparam logic [2:0] OPT_SB = 3'b011;

  // Buffer storage; address is kept without its byte-offset bits.
  logic [AW-3:0] entry_addr  [DEPTH];
  logic [31:0]   entry_wdata [DEPTH];
  logic [3:0]    entry_be    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          is_sw;
  logic          is_sh;
  logic          is_sb;
  logic          misaligned;
  logic          push;
  logic          pop;
  logic          fault;
  logic [31:0]   enc_wdata;
  logic [3:0]    enc_be;

  assign st_ready = (count < FULL_COUNT);
  assign busy     = (count != '0);
  assign mem_req  = busy;

  // Decode the store option and classify the request.
  always_comb begin
    is_sw      = (st_option == OPT_SW);
    is_sh      = (st_option == OPT_SH);
    is_sb      = (st_option == OPT_SB);
    misaligned = (is_sw && (st_addr[1:0] != 2'b00)) ||
                 (is_sh && st_addr[0]);
    push       = st_valid && st_ready && (is_sw || is_sh || is_sb) && !misaligned;
    fault      = st_valid && st_ready && misaligned;
    pop        = mem_req && mem_ack;
  end

  // Build byte enables and lane-replicated write data for the request.
  always_comb begin
    enc_wdata = '0;
    enc_be    = '0;
    if (is_sw) begin
      enc_wdata = st_data;
      enc_be    = 4'b1111;
    end else if (is_sh) begin
      enc_wdata = {st_data[15:0], st_data[15:0]};
      enc_be    = st_addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_sb) begin
      enc_wdata = {4{st_data[7:0]}};
      enc_be    = 4'b0001 << st_addr[1:0];
    end
  end

  // Write an accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr]  <= st_addr[AW-1:2];
      entry_wdata[wr_ptr] <= enc_wdata;
      entry_be[wr_ptr]    <= enc_be;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Misaligned-store exception: one-cycle pulse plus sticky faulting address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_ades <= 1'b0;
      exc_addr <= '0;
    end else begin
      exc_ades <= fault;
      if (fault) exc_addr <= st_addr;
    end
  end

  // Present the head entry; outputs read as zero while the buffer is empty.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    if (busy) begin
      mem_addr   = {entry_addr[rd_ptr], 2'b00};
      mem_wdata  = entry_wdata[rd_ptr];
      mem_byteen = entry_be[rd_ptr];
    end
  end

endmodule

// File: tb/tb_store_byte_packer.sv
// Self-checking bench for store_byte_packer: table of single-store vectors
// followed by hand-written multi-cycle sequences.
module tb_store_byte_packer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_option;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic        exc_ades;
  logic [31:0] exc_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  store_byte_packer #(.DEPTH(2), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_option  (st_option),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_ack    (mem_ack),
    .exc_ades   (exc_ades),
    .exc_addr   (exc_addr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = accepted, 1 = misaligned fault, 2 = ignored
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  option;
    int          kind;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_option = op;
  endtask

  task automatic idle_inputs();
    st_valid  = 1'b0;
    st_option = 3'b000;
    mem_ack   = 1'b0;
  endtask

  initial begin
    logic [31:0] last_exc;

    vecs[0]  = '{32'h0000_1004, 32'hDEAD_BEEF, 3'b001, 0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111};
    vecs[1]  = '{32'h0000_2003, 32'h0000_00A5, 3'b011, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000};
    vecs[2]  = '{32'h0000_2002, 32'h1234_5678, 3'b010, 0, 32'h0000_2000, 32'h5678_5678, 4'b1100};
    vecs[3]  = '{32'h0000_3001, 32'h1111_1111, 3'b010, 1, 32'h0,         32'h0,         4'b0000};
    vecs[4]  = '{32'h0000_3002, 32'h2222_2222, 3'b001, 1, 32'h0,         32'h0,         4'b0000};
    vecs[5]  = '{32'h0000_4000, 32'h0000_BEEF, 3'b010, 0, 32'h0000_4000, 32'hBEEF_BEEF, 4'b0011};
    vecs[6]  = '{32'h0000_5001, 32'h1122_3344, 3'b011, 0, 32'h0000_5000, 32'h4444_4444, 4'b0010};
    vecs[7]  = '{32'h0000_5002, 32'h1122_3355, 3'b011, 0, 32'h0000_5000, 32'h5555_5555, 4'b0100};
    vecs[8]  = '{32'h0000_6000, 32'h9999_9999, 3'b000, 2, 32'h0,         32'h0,         4'b0000};
    vecs[9]  = '{32'h0000_6001, 32'h8888_8888, 3'b111, 2, 32'h0,         32'h0,         4'b0000};
    vecs[10] = '{32'h0000_7003, 32'h7777_7777, 3'b001, 1, 32'h0,         32'h0,         4'b0000};

    reset     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_option = 3'b000;
    mem_ack   = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset_st_ready", {31'b0, st_ready}, 32'd1);
    check("reset_mem_req",  {31'b0, mem_req},  32'd0);
    check("reset_busy",     {31'b0, busy},     32'd0);
    check("reset_exc_ades", {31'b0, exc_ades}, 32'd0);
    check("reset_exc_addr", exc_addr,          32'd0);
    check("reset_mem_addr", mem_addr,          32'd0);
    check("reset_wdata",    mem_wdata,         32'd0);
    check("reset_byteen",   {28'b0, mem_byteen}, 32'd0);

    last_exc = 32'd0;
    for (int i = 0; i < 11; i++) begin
      drive_store(vecs[i].addr, vecs[i].data, vecs[i].option);
      tick();
      idle_inputs();
      if (vecs[i].kind == 0) begin
        check($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
        check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_byteen", i), {28'b0, mem_byteen}, {28'b0, vecs[i].exp_be});
        check($sformatf("v%0d_no_exc", i), {31'b0, exc_ades}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check($sformatf("v%0d_drained", i), {31'b0, busy}, 32'd0);
      end else if (vecs[i].kind == 1) begin
        last_exc = vecs[i].addr;
        check($sformatf("v%0d_exc_pulse", i), {31'b0, exc_ades}, 32'd1);
        check($sformatf("v%0d_exc_addr", i), exc_addr, last_exc);
        check($sformatf("v%0d_no_push", i), {31'b0, busy}, 32'd0);
        tick();
        check($sformatf("v%0d_exc_one_cycle", i), {31'b0, exc_ades}, 32'd0);
        check($sformatf("v%0d_exc_addr_hold", i), exc_addr, last_exc);
        check($sformatf("v%0d_still_idle", i), {31'b0, busy}, 32'd0);
      end else begin
        check($sformatf("v%0d_ignored_busy", i), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d_ignored_exc", i), {31'b0, exc_ades}, 32'd0);
        check($sformatf("v%0d_exc_addr_kept", i), exc_addr, last_exc);
      end
    end

    // Fill to capacity with no ack; third store must wait.
    drive_store(32'h10, 32'hA000_0010, 3'b001);
    tick();
    check("fill1_ready", {31'b0, st_ready}, 32'd1);
    check("fill1_addr", mem_addr, 32'h10);
    drive_store(32'h14, 32'hA000_0014, 3'b001);
    tick();
    check("fill2_full", {31'b0, st_ready}, 32'd0);
    check("fill2_head", mem_addr, 32'h10);
    drive_store(32'h18, 32'hA000_0018, 3'b001);
    tick();
    check("full_hold_addr", mem_addr, 32'h10);
    check("full_hold_wdata", mem_wdata, 32'hA000_0010);
    check("full_hold_ready", {31'b0, st_ready}, 32'd0);
    // Ack while full: pop only, the held store is not yet taken.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("pop1_head", mem_addr, 32'h14);
    check("pop1_wdata", mem_wdata, 32'hA000_0014);
    check("pop1_ready", {31'b0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
    check("push3_full", {31'b0, st_ready}, 32'd0);
    check("push3_head_stable", mem_addr, 32'h14);
    mem_ack = 1'b1;
    tick();
    check("pop2_head", mem_addr, 32'h18);
    check("pop2_wdata", mem_wdata, 32'hA000_0018);
    tick();
    mem_ack = 1'b0;
    check("pop3_empty", {31'b0, busy}, 32'd0);

    // Push and pop in the same cycle at count = 1.
    drive_store(32'h20, 32'hB000_0020, 3'b001);
    tick();
    drive_store(32'h21, 32'h0000_00CC, 3'b011);
    mem_ack = 1'b1;
    tick();
    idle_inputs();
    check("pp_busy", {31'b0, busy}, 32'd1);
    check("pp_ready", {31'b0, st_ready}, 32'd1);
    check("pp_head_addr", mem_addr, 32'h20);
    check("pp_head_be", {28'b0, mem_byteen}, 32'b0010);
    check("pp_head_wdata", mem_wdata, 32'hCCCC_CCCC);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("pp_drained", {31'b0, busy}, 32'd0);

    // Misaligned request while full is not flagged; then async reset mid-cycle.
    drive_store(32'h40, 32'hC000_0040, 3'b001);
    tick();
    drive_store(32'h44, 32'hC000_0044, 3'b001);
    tick();
    drive_store(32'h45, 32'hC000_0045, 3'b001);
    tick();
    st_valid = 1'b0;
    check("full_mis_no_exc", {31'b0, exc_ades}, 32'd0);
    check("full_mis_exc_addr", exc_addr, last_exc);
    check("full_mis_head", mem_addr, 32'h40);
    #2 reset = 1'b1;
    #1;
    check("arst_mem_req", {31'b0, mem_req}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, st_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'b0, st_ready}, 32'd1);
    check("post_rst_addr", mem_addr, 32'd0);

    // Pending exception pulse cleared by reset.
    drive_store(32'h3001, 32'h0, 3'b010);
    tick();
    st_valid = 1'b0;
    check("rst_exc_before", {31'b0, exc_ades}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_exc_cleared", {31'b0, exc_ades}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
